alu_muldiv: RTL and testbench



---
 rtl/alu_muldiv.sv | 167 ++++++++++++++++
 tb/tb_alu_muldiv.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// Execute-stage ALU: combinational single-cycle ops plus an optional iterative mul/div unit.
// The multi-cycle unit (FSM, operand and result registers) is built only when ALU_MULDIV_EN is defined.
module alu_muldiv #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    input  logic [3:0]      ALUControl,
    input  logic            Start,
    output logic [XLEN-1:0] ALUResult,
    output logic            Zero,
    output logic            Busy,
    output logic            Done
);
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;

    logic [XLEN-1:0] single_result;
    logic [SHW-1:0]  shamt;
    logic            is_multi;

    assign shamt    = SrcB[SHW-1:0];
    // Codes 1010..1111 are the multi-cycle group.
    assign is_multi = ALUControl[3] & (ALUControl[2] | ALUControl[1]);

    always_comb begin
        single_result = '0;
        case (ALUControl)
            OP_ADD:  single_result = SrcA + SrcB;
            OP_SUB:  single_result = SrcA - SrcB;
            OP_AND:  single_result = SrcA & SrcB;
            OP_OR:   single_result = SrcA | SrcB;
            OP_XOR:  single_result = SrcA ^ SrcB;
            OP_SLT:  single_result = {{(XLEN-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            OP_SLTU: single_result = {{(XLEN-1){1'b0}}, (SrcA < SrcB)};
            OP_SLL:  single_result = SrcA << shamt;
            OP_SRL:  single_result = SrcA >> shamt;
            OP_SRA:  single_result = $unsigned($signed(SrcA) >>> shamt);
            default: single_result = '0;
        endcase
    end

`ifdef ALU_MULDIV_EN
    localparam logic [3:0] OP_MULHU = 4'b1011;
    localparam logic [3:0] OP_DIV   = 4'b1100;
    localparam logic [3:0] OP_DIVU  = 4'b1101;
    localparam logic [3:0] OP_REM   = 4'b1110;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t          state_reg, state_next;
    logic [XLEN-1:0] acc_reg, q_reg, b_reg, result_reg, final_result;
    logic [3:0]      op_reg;
    logic [SHW:0]    count_reg;
    logic            neg_q_reg, neg_r_reg, div0_reg;
    logic            steps_done, op_is_mul, signed_div, a_neg, b_neg;
    logic [XLEN:0]   mul_sum, div_shift, div_diff;

    assign steps_done = (count_reg == (SHW+1)'(XLEN));
    assign op_is_mul  = (op_reg[3:1] == 3'b101);
    assign signed_div = (ALUControl == OP_DIV) || (ALUControl == OP_REM);
    assign a_neg      = signed_div & SrcA[XLEN-1];
    assign b_neg      = signed_div & SrcB[XLEN-1];

    // acc holds the product high half / partial remainder; q holds multiplier / dividend-then-quotient.
    assign mul_sum   = {1'b0, acc_reg} + (q_reg[0] ? {1'b0, b_reg} : '0);
    assign div_shift = {acc_reg, q_reg[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, b_reg};

    always_comb begin
        final_result = '0;
        case (op_reg)
            OP_MULHU:        final_result = acc_reg;
            OP_DIV, OP_DIVU: final_result = div0_reg ? '1 : (neg_q_reg ? -q_reg : q_reg);
            OP_REM, 4'b1111: final_result = neg_r_reg ? -acc_reg : acc_reg;
            default:         final_result = q_reg;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        Busy       = 1'b0;
        Done       = 1'b0;
        case (state_reg)
            IDLE: if (Start && is_multi) state_next = RUN;
            RUN: begin
                Busy = 1'b1;
                if (steps_done) state_next = FIN;
            end
            FIN: begin
                Busy       = 1'b1;
                Done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            acc_reg    <= '0;
            q_reg      <= '0;
            b_reg      <= '0;
            result_reg <= '0;
            op_reg     <= '0;
            count_reg  <= '0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            div0_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE) begin
                if (Start && is_multi) begin
                    op_reg    <= ALUControl;
                    acc_reg   <= '0;
                    q_reg     <= a_neg ? -SrcA : SrcA;
                    b_reg     <= b_neg ? -SrcB : SrcB;
                    neg_q_reg <= a_neg ^ b_neg;
                    neg_r_reg <= a_neg;
                    div0_reg  <= (SrcB == '0);
                    count_reg <= '0;
                end
            end else if (state_reg == RUN) begin
                // The extra cycle after the last step applies sign fix-up into the result register.
                if (steps_done) begin
                    result_reg <= final_result;
                end else begin
                    count_reg <= count_reg + (SHW+1)'(1);
                    if (op_is_mul) begin
                        acc_reg <= mul_sum[XLEN:1];
                        q_reg   <= {mul_sum[0], q_reg[XLEN-1:1]};
                    end else if (!div_diff[XLEN]) begin
                        acc_reg <= div_diff[XLEN-1:0];
                        q_reg   <= {q_reg[XLEN-2:0], 1'b1};
                    end else begin
                        acc_reg <= div_shift[XLEN-1:0];
                        q_reg   <= {q_reg[XLEN-2:0], 1'b0};
                    end
                end
            end
        end
    end

    assign ALUResult = is_multi ? result_reg : single_result;
`else
    logic unused_inputs;
    assign unused_inputs = ^{clk, rst, Start};
    assign ALUResult     = is_multi ? '0 : single_result;
    assign Busy          = 1'b0;
    assign Done          = 1'b0;
`endif

    assign Zero = (ALUResult == '0);

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv (XLEN=32); expectations follow the build's ALU_MULDIV_EN setting.
module tb_alu_muldiv;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [XLEN-1:0] SrcA, SrcB;
    logic [3:0]      ALUControl;
    logic            Start;
    logic [XLEN-1:0] ALUResult;
    logic            Zero, Busy, Done;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];

    alu_muldiv #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl),
        .Start(Start), .ALUResult(ALUResult), .Zero(Zero), .Busy(Busy), .Done(Done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        logic [63:0]        p;
        logic               ovf;
        sa  = a;
        sb  = b;
        p   = {32'b0, a} * {32'b0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd6:  return (a < b) ? 32'd1 : 32'd0;
            4'd7:  return a << b[4:0];
            4'd8:  return a >> b[4:0];
            4'd9:  return sa >>> b[4:0];
`ifdef ALU_MULDIV_EN
            4'd10: return p[31:0];
            4'd11: return p[63:32];
            4'd12: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : sa / sb);
            4'd13: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd14: return (b == 0) ? a : (ovf ? 32'd0 : sa % sb);
            4'd15: return (b == 0) ? a : a % b;
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic pop_check();
        sb_t e;
        if (sb_q.size() == 0) begin
            check("sb_empty", 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            check(e.tag, ALUResult, e.exp);
            check({e.tag, "_zero"}, Zero, (e.exp == 0));
            $display("txn %s op=%h a=%h b=%h result=%h", e.tag, ALUControl, SrcA, SrcB, ALUResult);
        end
    endtask

    task automatic single(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
        @(negedge clk);
        SrcA = a; SrcB = b; ALUControl = op;
        sb_q.push_back('{tag, ref_op(op, a, b)});
        #1 pop_check();
    endtask

    task automatic do_multi(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input bit disturb, input string tag);
        int cycles;
        bit seen;
        bit any;
        @(negedge clk);
        SrcA = a; SrcB = b; ALUControl = op; Start = 1'b1;
        sb_q.push_back('{tag, ref_op(op, a, b)});
        @(negedge clk);
        Start = 1'b0;
`ifdef ALU_MULDIV_EN
        check({tag, "_busy"}, Busy, 1);
        cycles = 0;
        seen   = 0;
        while (!seen && cycles < 100) begin
            @(negedge clk);
            cycles++;
            if (disturb && cycles == 3) begin
                SrcA = 32'h1234_5678; SrcB = 32'h0000_0003; ALUControl = 4'hD; Start = 1'b1;
            end
            if (disturb && cycles == 4) Start = 1'b0;
            if (Done) seen = 1;
        end
        check({tag, "_latency"}, cycles, XLEN + 1);
        pop_check();
        @(negedge clk);
        check({tag, "_done_pulse"}, {Done, Busy}, 2'b00);
`else
        any = 0;
        for (int i = 0; i < XLEN + 4; i++) begin
            @(negedge clk);
            if (Busy || Done) any = 1;
        end
        check({tag, "_no_busy_done"}, any, 0);
        pop_check();
`endif
    endtask

    initial begin
        int cycles;
        bit seen;
        logic [3:0]  op;
        logic [31:0] a, b;

        rst = 1'b1; Start = 1'b0; SrcA = '0; SrcB = '0; ALUControl = 4'hA;
        repeat (3) @(negedge clk);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_result", ALUResult, 0);
        check("rst_zero", Zero, 1);
        rst = 1'b0;

        single(4'd0, 32'hFFFF_FFFF, 32'd1, "add_wrap");
        single(4'd9, 32'h8000_0000, 32'd4, "sra");
        single(4'd5, 32'hFFFF_FFFF, 32'd1, "slt");
        single(4'd6, 32'hFFFF_FFFF, 32'd1, "sltu");
        single(4'd7, 32'h0000_0001, 32'hFFFF_FFFF, "sll_b31");
        single(4'd1, 32'd5, 32'd7, "sub");

        do_multi(4'hA, 32'h0001_2345, 32'h0000_0100, 0, "mul");
        do_multi(4'hB, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhu");
        do_multi(4'hC, -32'sd7, 32'd2, 0, "div_neg");
        do_multi(4'hE, -32'sd7, 32'd2, 0, "rem_neg");
        do_multi(4'hD, 32'd100, 32'd7, 0, "divu");
        do_multi(4'hF, 32'd100, 32'd7, 0, "remu");
        do_multi(4'hD, 32'd5, 32'd0, 0, "divu_by0");
        do_multi(4'hE, 32'd5, 32'd0, 0, "rem_by0");
        do_multi(4'hC, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
        do_multi(4'hE, 32'h8000_0000, 32'hFFFF_FFFF, 0, "rem_ovf");
        do_multi(4'hA, 32'h0000_0BAD, 32'h0000_0010, 1, "mul_disturbed");

`ifdef ALU_MULDIV_EN
        @(negedge clk);
        SrcA = 32'd1000; SrcB = 32'd3; ALUControl = 4'hD; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrun_rst_busy", Busy, 0);
        check("midrun_rst_result", ALUResult, 0);
        seen = 0;
        for (int i = 0; i < XLEN + 8; i++) begin
            @(negedge clk);
            if (Done || Busy) seen = 1;
        end
        check("midrun_rst_no_done", seen, 0);
`endif
        do_multi(4'hD, 32'd1000, 32'd3, 0, "after_rst");

        for (int i = 0; i < 8; i++) begin
            op = 4'($urandom_range(0, 9));
            a  = $urandom;
            b  = $urandom;
            single(op, a, b, "rand_single");
        end
        for (int i = 0; i < 8; i++) begin
            op = 4'($urandom_range(10, 15));
            a  = $urandom;
            b  = (i % 3 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            do_multi(op, a, b, 0, "rand_multi");
        end
        single(4'd0, 32'd2, 32'd3, "add_final");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
